instr_fetch_queue: RTL and testbench

Instruction prefetch unit sitting directly upstream of the pipelined CPU core. It walks an 11-bit program counter, issues in-order read requests to instruction memory, buffers returned words in a small FIFO, and presents the FIFO head to the core's fetch stage through the `instruction_fetch` / `fifo_empty` / `read_fifo` handshake. A taken branch from the core's execute stage flushes the queue, drops in-flight responses, and restarts fetch at `branch_address`.

---
 rtl/instr_fetch_queue_if.sv | 19 +
 rtl/instr_fetch_queue.sv | 100 ++++++++++
 tb/tb_instr_fetch_queue.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: instruction memory read bus.
// master = prefetcher (req/addr out), slave = memory (ready/rvalid/rdata out).
interface instr_fetch_queue_if;
  logic        imem_req;
  logic [10:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC walker, in-order imem reads, DEPTH-entry FIFO to core.
// Ports: clk, resetn (sync), branch_*, read_fifo, instruction_fetch, fifo_empty,
// imem bus (master); IFQ_STATS_EN adds fetch_count and flush_count.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [10:0] RESET_PC = 11'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        branch_valid,
  input  logic [10:0] branch_address,
  input  logic        read_fifo,
  output logic [31:0] instruction_fetch,
  output logic        fifo_empty,
`ifdef IFQ_STATS_EN
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count,
`endif
  instr_fetch_queue_if.master imem
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

  logic [10:0]   pc;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW:0]   credit;
  logic          issue;
  logic          stale;
  logic          push;
  logic          pop;

  // In-flight requests reserve a slot, so a push never meets a full FIFO.
  assign credit = {1'b0, count} + {1'b0, outstanding};

  assign imem.imem_req  = resetn && !branch_valid
                        && (credit < DEPTH_S);
  assign imem.imem_addr = pc;

  assign issue = imem.imem_req && imem.imem_ready;
  assign stale = (drop != '0);
  assign push  = imem.imem_rvalid && !stale && !branch_valid;
  assign pop   = read_fifo && (count != '0) && !branch_valid;

  assign fifo_empty        = (count == '0);
  assign instruction_fetch = fifo_empty ? 32'h0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= imem.imem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue)
                   - CW'(imem.imem_rvalid);
      if (branch_valid) begin
        pc     <= branch_address;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // Everything still in flight after this edge predates the flush.
        drop   <= outstanding - CW'(imem.imem_rvalid);
      end else begin
        if (issue) pc <= pc + 11'd1;
        if (imem.imem_rvalid && stale) drop <= drop - CW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef IFQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push && (fetch_count != '1))
        fetch_count <= fetch_count + 32'd1;
      if (branch_valid && (flush_count != '1))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: random/directed bench with epoch-tagged memory model.
// Memory returns {21'h0, addr}; FIFO modelled as a queue of words.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [10:0] RESET_PC = 11'd0;

  logic        clk;
  logic        resetn;
  logic        branch_valid;
  logic [10:0] branch_address;
  logic        read_fifo;
  logic [31:0] instruction_fetch;
  logic        fifo_empty;
`ifdef IFQ_STATS_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  instr_fetch_queue_if bus();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .resetn(resetn),
    .branch_valid(branch_valid),
    .branch_address(branch_address),
    .read_fifo(read_fifo),
    .instruction_fetch(instruction_fetch),
    .fifo_empty(fifo_empty),
`ifdef IFQ_STATS_EN
    .fetch_count(fetch_count),
    .flush_count(flush_count),
`endif
    .imem(bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [10:0] addr;
    logic [10:0] exp;
    int          ep;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] q[$];
  logic [10:0] acc[$];
  logic [10:0] mpc;
  int epoch, cyc, lat, rdy_pct;
  int n_assert, n_fail, n_push, n_flush;
  logic [31:0] nxt;

  task automatic step(input logic rst, input logic bv,
                      input logic [10:0] ba, input logic rf);
    logic rv, er, took;
    logic [31:0] hd;
    logic [10:0] a0;
    req_t e;
    resetn = !rst;
    branch_valid = bv;
    branch_address = ba;
    read_fifo = rf;
    rv = !rst && (pend.size() > 0) && (pend[0].due <= cyc);
    bus.imem_rvalid = rv;
    bus.imem_rdata = rv ? {21'h0, pend[0].addr} : $urandom();
    bus.imem_ready = ($urandom_range(0, 99) < rdy_pct);
    #4;
    er = !rst && !bv && (q.size() + pend.size() < DEPTH);
    n_assert++;
    if (bus.imem_req !== er) begin
      n_fail++;
      $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, bus.imem_req, er);
    end
    if (!rst) begin
      hd = 32'h0;
      if (q.size() > 0) hd = q[0];
      n_assert++;
      if (bus.imem_addr !== mpc) begin
        n_fail++;
        $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, mpc);
      end
      n_assert++;
      if (fifo_empty !== (q.size() == 0)) begin
        n_fail++;
        $display("FAIL fifo_empty cyc=%0d got=%b exp=%b", cyc, fifo_empty, q.size() == 0);
      end
      n_assert++;
      if (instruction_fetch !== hd) begin
        n_fail++;
        $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, instruction_fetch, hd);
      end
`ifdef IFQ_STATS_EN
      n_assert++;
      if (fetch_count !== 32'(n_push)) begin
        n_fail++;
        $display("FAIL fetch_count cyc=%0d got=%0d exp=%0d", cyc, fetch_count, n_push);
      end
      n_assert++;
      if (flush_count !== 16'(n_flush)) begin
        n_fail++;
        $display("FAIL flush_count cyc=%0d got=%0d exp=%0d", cyc, flush_count, n_flush);
      end
`endif
    end
    took = (bus.imem_req === 1'b1) && bus.imem_ready;
    if (rst) begin
      q.delete();
      pend.delete();
      mpc = RESET_PC;
      n_push = 0;
      n_flush = 0;
      epoch++;
    end else begin
      a0 = mpc;
      if (rv) e = pend.pop_front();
      if (took) begin
        acc.push_back(bus.imem_addr);
        pend.push_back('{addr: bus.imem_addr, exp: a0,
                         ep: (bv ? -1 : epoch), due: cyc + lat});
      end
      if (bv) begin
        q.delete();
        epoch++;
        mpc = ba;
        n_flush++;
      end else begin
        if (rf && q.size() > 0) void'(q.pop_front());
        if (rv && e.ep == epoch) begin
          q.push_back({21'h0, e.exp});
          n_push++;
        end
        if (er && bus.imem_ready) mpc = mpc + 11'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    n_assert++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req got=%b exp=0", bus.imem_req);
    end
    n_assert++;
    if (bus.imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL rst_addr got=%h exp=%h", bus.imem_addr, RESET_PC);
    end
    n_assert++;
    if (fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_empty got=%b exp=1", fifo_empty);
    end
    n_assert++;
    if (instruction_fetch !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_instr got=%h exp=0", instruction_fetch);
    end
  endtask

  task automatic test_stream;
    int nonempty;
    lat = 1;
    rdy_pct = 100;
    test_reset();
    nonempty = 0;
    nxt = 32'h0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 1);
      if (!fifo_empty) begin
        nonempty++;
        n_assert++;
        if (instruction_fetch !== nxt) begin
          n_fail++;
          $display("FAIL stream_word got=%h exp=%h", instruction_fetch, nxt);
        end
        if (i < 29) nxt++;
      end
    end
    n_assert++;
    if (nonempty != 29) begin
      n_fail++;
      $display("FAIL stream_rate got=%0d exp=29", nonempty);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    n_assert++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_req got=%b exp=0", bus.imem_req);
    end
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (instruction_fetch !== nxt + 32'(i)) begin
        n_fail++;
        $display("FAIL stall_order got=%h exp=%h", instruction_fetch, nxt + 32'(i));
      end
      step(0, 0, 0, 1);
    end
  endtask

  task automatic test_flush_latency;
    bit seen;
    lat = 3;
    rdy_pct = 100;
    test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 11'h040, 1);
    branch_valid = 1'b0;
    #1;
    n_assert++;
    if (fifo_empty !== 1'b1 || instruction_fetch !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_empty got=%b/%h exp=1/0", fifo_empty, instruction_fetch);
    end
    n_assert++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h040) begin
      n_fail++;
      $display("FAIL flush_restart got=%b/%h exp=1/040", bus.imem_req, bus.imem_addr);
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 0, 0, 0);
      seen = !fifo_empty;
    end
    n_assert++;
    if (!seen || instruction_fetch !== 32'h40) begin
      n_fail++;
      $display("FAIL flush_first got=%h seen=%0d exp=00000040", instruction_fetch, seen);
    end
    lat = 1;
  endtask

  task automatic test_wrap;
    logic [10:0] ex [4];
    ex[0] = 11'h7FE; ex[1] = 11'h7FF; ex[2] = 11'h000; ex[3] = 11'h001;
    step(0, 1, 11'h7FE, 1);
    acc.delete();
    for (int i = 0; i < 40 && acc.size() < 4; i++) step(0, 0, 0, 1);
    n_assert++;
    if (acc.size() < 4) begin
      n_fail++;
      $display("FAIL wrap_timeout got=%0d exp=4", acc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_assert++;
        if (acc[i] !== ex[i]) begin
          n_fail++;
          $display("FAIL wrap_addr%0d got=%h exp=%h", i, acc[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_flush_collide;
    bit ok, seen;
    lat = 1;
    rdy_pct = 100;
    test_reset();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(0, 0, 0, 0);
      ok = (q.size() == 2) && (pend.size() > 0) && (pend[0].due <= cyc);
    end
    n_assert++;
    if (!ok || fifo_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_setup got=%0d exp=1", ok);
    end
    step(0, 1, 11'h123, 1);
    branch_valid = 1'b0;
    read_fifo = 1'b0;
    #1;
    n_assert++;
    if (fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_empty got=%b exp=1", fifo_empty);
    end
    n_assert++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h123) begin
      n_fail++;
      $display("FAIL collide_restart got=%b/%h exp=1/123", bus.imem_req, bus.imem_addr);
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 0, 0, 0);
      seen = !fifo_empty;
    end
    n_assert++;
    if (!seen || instruction_fetch !== 32'h123) begin
      n_fail++;
      $display("FAIL collide_first got=%h exp=00000123", instruction_fetch);
    end
  endtask

  task automatic test_random;
    test_reset();
    for (int i = 0; i < 2500; i++) begin
      if (i % 100 == 0 && pend.size() == 0) lat = $urandom_range(1, 4);
      rdy_pct = 75;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 6),
           11'($urandom()),
           ($urandom_range(0, 99) < 60));
    end
    rdy_pct = 100;
    lat = 1;
  endtask

`ifdef IFQ_STATS_EN
  task automatic test_stats;
    int i;
    lat = 1;
    rdy_pct = 100;
    test_reset();
    i = 0;
    while (n_push < 20 && i < 200) begin
      step(0, (i == 5 || i == 10 || i == 15), 11'(i * 7), 1);
      i++;
    end
    n_assert++;
    if (fetch_count !== 32'd20 || flush_count !== 16'd3) begin
      n_fail++;
      $display("FAIL stats_count got=%0d/%0d exp=20/3", fetch_count, flush_count);
    end
    step(1, 0, 0, 0);
    n_assert++;
    if (fetch_count !== 32'd0 || flush_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset got=%0d/%0d exp=0/0", fetch_count, flush_count);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail = 0;
    n_push = 0;
    n_flush = 0;
    epoch = 0;
    cyc = 0;
    lat = 1;
    rdy_pct = 100;
    mpc = RESET_PC;
    resetn = 1'b0;
    branch_valid = 1'b0;
    branch_address = '0;
    read_fifo = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_latency();
    test_wrap();
    test_flush_collide();
    test_random();
`ifdef IFQ_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
